// File: rtl/usbh_pkt_fifo.sv
// Packet-aware byte FIFO between the USB host SIE receive path and the reader.
// Writes are speculative until committed; rollback rewinds to the last commit point.
module usbh_pkt_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 64,
  parameter int ADDR_W     = 6,
  parameter int AFULL_LVL  = 56,
  parameter int AEMPTY_LVL = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [WIDTH-1:0]  data_i,
  input  logic              push_i,
  input  logic              commit_i,
  input  logic              rollback_i,
  input  logic              pop_i,
  input  logic              flush_i,
  output logic [WIDTH-1:0]  data_o,
  output logic              full_o,
  output logic              empty_o,
  output logic              afull_o,
  output logic              aempty_o,
  output logic [ADDR_W:0]   level_o,
  output logic [ADDR_W:0]   pending_o,
  output logic              overflow_o
);

  localparam int CNT_W = ADDR_W + 1;

  logic [WIDTH-1:0]  ram_q [DEPTH];

  logic [ADDR_W-1:0] rd_ptr_q,  rd_ptr_d;
  logic [ADDR_W-1:0] cmt_ptr_q, cmt_ptr_d;
  logic [ADDR_W-1:0] wr_ptr_q,  wr_ptr_d;
  logic [ADDR_W-1:0] wr_adv;
  logic [CNT_W-1:0]  level_q,   level_d;
  logic [CNT_W-1:0]  pending_q, pending_d;
  logic              ovf_q,     ovf_d;

  logic [CNT_W-1:0]  used;
  logic              push_ok;
  logic              pop_ok;

  // Accept decisions look only at registered state, never at this cycle's ops.
  assign used     = level_q + pending_q;
  assign full_o   = (used == CNT_W'(DEPTH));
  assign empty_o  = (level_q == '0);
  assign afull_o  = (used >= CNT_W'(AFULL_LVL));
  assign aempty_o = (level_q <= CNT_W'(AEMPTY_LVL));
  assign level_o    = level_q;
  assign pending_o  = pending_q;
  assign overflow_o = ovf_q;
  assign data_o     = ram_q[rd_ptr_q];

  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;
  assign wr_adv  = wr_ptr_q + ADDR_W'(push_ok);

  always_comb begin
    rd_ptr_d  = rd_ptr_q;
    cmt_ptr_d = cmt_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    level_d   = level_q;
    pending_d = pending_q;
    ovf_d     = ovf_q;
    if (flush_i) begin
      rd_ptr_d  = '0;
      cmt_ptr_d = '0;
      wr_ptr_d  = '0;
      level_d   = '0;
      pending_d = '0;
      ovf_d     = 1'b0;
    end else begin
      rd_ptr_d = rd_ptr_q + ADDR_W'(pop_ok);
      if (rollback_i) begin
        // A same-cycle push may land in RAM but is dropped by rewinding wr_ptr.
        wr_ptr_d  = cmt_ptr_q;
        pending_d = '0;
        level_d   = level_q - CNT_W'(pop_ok);
        ovf_d     = 1'b0;
      end else if (commit_i) begin
        wr_ptr_d  = wr_adv;
        cmt_ptr_d = wr_adv;
        level_d   = level_q + pending_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
        pending_d = '0;
        ovf_d     = 1'b0;
      end else begin
        wr_ptr_d  = wr_adv;
        pending_d = pending_q + CNT_W'(push_ok);
        level_d   = level_q - CNT_W'(pop_ok);
        if (push_i && full_o) ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr_q  <= '0;
      cmt_ptr_q <= '0;
      wr_ptr_q  <= '0;
      level_q   <= '0;
      pending_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      rd_ptr_q  <= rd_ptr_d;
      cmt_ptr_q <= cmt_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      level_q   <= level_d;
      pending_q <= pending_d;
      ovf_q     <= ovf_d;
    end
  end

  // Storage carries no reset; only the pointers decide what is valid.
  always_ff @(posedge clk_i) begin
    if (push_ok && !flush_i && !rst_i) ram_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: tb/tb_usbh_pkt_fifo.sv
// Bench for usbh_pkt_fifo: directed packet scenarios plus random traffic,
// all checked against a queue-based packet model.
module tb_usbh_pkt_fifo;

  localparam int WIDTH      = 8;
  localparam int DEPTH      = 64;
  localparam int ADDR_W     = 6;
  localparam int AFULL_LVL  = 56;
  localparam int AEMPTY_LVL = 8;

  logic              clk = 1'b0;
  logic              rst, push, commit, rollback, pop, flush;
  logic [WIDTH-1:0]  din;
  logic [WIDTH-1:0]  dout;
  logic              full, empty, afull, aempty, ovf;
  logic [ADDR_W:0]   level, pending;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] cq[$];
  logic [7:0] pq[$];
  logic       m_ovf = 1'b0;

  usbh_pkt_fifo #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W),
    .AFULL_LVL(AFULL_LVL), .AEMPTY_LVL(AEMPTY_LVL)
  ) dut (
    .clk_i(clk), .rst_i(rst), .data_i(din), .push_i(push),
    .commit_i(commit), .rollback_i(rollback), .pop_i(pop), .flush_i(flush),
    .data_o(dout), .full_o(full), .empty_o(empty), .afull_o(afull),
    .aempty_o(aempty), .level_o(level), .pending_o(pending), .overflow_o(ovf)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    int used;
    used = cq.size() + pq.size();
    check_eq("level",    32'(level),   32'(cq.size()));
    check_eq("pending",  32'(pending), 32'(pq.size()));
    check_eq("empty",    32'(empty),   32'(cq.size() == 0));
    check_eq("full",     32'(full),    32'(used == DEPTH));
    check_eq("afull",    32'(afull),   32'(used >= AFULL_LVL));
    check_eq("aempty",   32'(aempty),  32'(cq.size() <= AEMPTY_LVL));
    check_eq("overflow", 32'(ovf),     32'(m_ovf));
    if (cq.size() != 0) check_eq("data", 32'(dout), 32'(cq[0]));
  endtask

  // One clock: drive, advance the model by the packet rules, then compare.
  task automatic step(input logic p, input logic [7:0] d, input logic po,
                      input logic cm, input logic rb, input logic fl, input logic rs);
    bit m_full, m_empty;
    @(negedge clk);
    push = p; din = d; pop = po; commit = cm; rollback = rb; flush = fl; rst = rs;
    m_full  = (cq.size() + pq.size()) == DEPTH;
    m_empty = (cq.size() == 0);
    if (rs || fl) begin
      cq.delete(); pq.delete(); m_ovf = 1'b0;
    end else begin
      if (po && !m_empty) void'(cq.pop_front());
      if (p && !m_full) pq.push_back(d);
      if (rb) begin
        pq.delete(); m_ovf = 1'b0;
      end else if (cm) begin
        while (pq.size() != 0) cq.push_back(pq.pop_front());
        m_ovf = 1'b0;
      end else if (p && m_full) begin
        m_ovf = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic push_b(input logic [7:0] d); step(1, d, 0, 0, 0, 0, 0); endtask
  task automatic pop_b();                     step(0, 0, 1, 0, 0, 0, 0); endtask
  task automatic do_commit();                 step(0, 0, 0, 1, 0, 0, 0); endtask
  task automatic do_rollback();               step(0, 0, 0, 0, 1, 0, 0); endtask

  initial begin
    rst = 1; push = 0; pop = 0; commit = 0; rollback = 0; flush = 0; din = '0;
    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 1);
    check_eq("rst_empty", 32'(empty), 32'd1);
    check_eq("rst_afull", 32'(afull), 32'd0);

    // Speculative push hidden until commit.
    push_b(8'h11); push_b(8'h22); push_b(8'h33);
    check_eq("t1_pend", 32'(pending), 32'd3);
    do_commit();
    check_eq("t1_lvl", 32'(level), 32'd3);
    repeat (3) pop_b();

    // Rollback discards only the open packet.
    push_b(8'hA0); push_b(8'hB0); do_commit();
    push_b(8'hC0); push_b(8'hD0); do_rollback();
    push_b(8'hE0); do_commit();
    check_eq("t2_lvl", 32'(level), 32'd3);
    repeat (3) pop_b();

    // Fill to capacity, overflow attempt, commit, drain.
    for (int i = 0; i < DEPTH; i++) push_b(8'(i * 3 + 1));
    check_eq("t3_full", 32'(full), 32'd1);
    push_b(8'hFF);
    check_eq("t3_ovf", 32'(ovf), 32'd1);
    do_commit();
    check_eq("t3_lvl", 32'(level), 32'd64);
    for (int i = 0; i < DEPTH; i++) pop_b();

    // Push, pop and commit in the same cycle.
    for (int i = 0; i < 5; i++) push_b(8'(8'h50 + i));
    do_commit();
    step(1, 8'h77, 1, 1, 0, 0, 0);
    check_eq("t4_lvl", 32'(level), 32'd5);
    repeat (5) pop_b();

    // Pointer wrap.
    for (int it = 0; it < 3; it++) begin
      for (int i = 0; i < 40; i++) push_b(8'($urandom));
      do_commit();
      for (int i = 0; i < 40; i++) pop_b();
    end

    // Flush with a push in the same cycle, then reset mid-packet.
    for (int i = 0; i < 10; i++) push_b(8'(i));
    do_commit();
    for (int i = 0; i < 4; i++) push_b(8'(8'h80 + i));
    step(1, 8'h99, 1, 0, 0, 1, 0);
    check_eq("t6_flush_lvl", 32'(level), 32'd0);
    push_b(8'h42); do_commit(); pop_b();
    for (int i = 0; i < 10; i++) push_b(8'(i));
    do_commit();
    for (int i = 0; i < 4; i++) push_b(8'(8'h90 + i));
    step(1, 8'h5A, 0, 0, 0, 0, 1);
    check_eq("t6_rst_pend", 32'(pending), 32'd0);

    // Random traffic with shifting bias so the FIFO swings full and empty.
    for (int ph = 0; ph < 8; ph++) begin
      int pp;
      pp = (ph % 2 == 0) ? 80 : 30;
      for (int c = 0; c < 300; c++) begin
        step($urandom_range(99) < pp, 8'($urandom), $urandom_range(99) < (100 - pp),
             $urandom_range(99) < 12, $urandom_range(99) < 4,
             $urandom_range(999) < 5, $urandom_range(999) < 3);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
